// File: rtl/hex_nibble_entry.sv
// Debounced four-key nibble editor: INC/DEC/CLEAR edit a nibble, COMMIT latches it for SEG_HEX.
// Define AUTOREPEAT_EN to add hold-to-repeat on INC/DEC.
module hex_nibble_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [3:0] EDIT,
    output logic [3:0] NUMBER,
    output logic       NUMBER_VLD,
    output logic [3:0] KEY_STATE
);
    localparam int unsigned NKEYS = 4;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
        $error("hex_nibble_entry: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* must be non-zero");
    end

    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] ks_prev;
    logic [CNT_W-1:0] cnt [NKEYS];
    logic [NKEYS-1:0] s_c;
    logic [NKEYS-1:0] press_c;
    logic             rep_inc_c;
    logic             rep_dec_c;
    logic             inc_c;
    logic             dec_c;
    logic             clr_c;
    logic             commit_c;
    logic [3:0]       edit_nxt_c;

    // Two-flop synchroniser; keys idle released (1) out of reset
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    assign s_c     = ~sync2;
    assign press_c = KEY_STATE & ~ks_prev;

    // Per-key debounce: level accepted after DEBOUNCE_CYCLES consecutive mismatched cycles
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            KEY_STATE <= '0;
            ks_prev   <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ks_prev <= KEY_STATE;
            for (int i = 0; i < NKEYS; i++) begin
                if (s_c[i] == KEY_STATE[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    KEY_STATE[i] <= s_c[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
    logic             rep_hold_c;
    logic             rep_fire_c;

    // rep_cnt holds cycles since the last press/repeat; zero means idle
    assign rep_hold_c = (KEY_STATE[0] | KEY_STATE[1]) & ~KEY_STATE[2];
    assign rep_fire_c = rep_hold_c && (rep_cnt != '0) &&
                        (rep_cnt == (rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD)));
    assign rep_inc_c  = rep_fire_c & KEY_STATE[0];
    assign rep_dec_c  = rep_fire_c & KEY_STATE[1];

    always_ff @(posedge CLOCK_50) begin
        if (RESET || !rep_hold_c) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (press_c[0] || press_c[1]) begin
            rep_cnt   <= REP_W'(1);
            rep_first <= 1'b1;
        end else if (rep_fire_c) begin
            rep_cnt   <= REP_W'(1);
            rep_first <= 1'b0;
        end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end
`else
    assign rep_inc_c = 1'b0;
    assign rep_dec_c = 1'b0;
`endif

    // Next edit value; CLEAR wins, INC+DEC together cancel
    always_comb begin
        inc_c      = press_c[0] | rep_inc_c;
        dec_c      = press_c[1] | rep_dec_c;
        clr_c      = press_c[2];
        commit_c   = press_c[3];
        edit_nxt_c = EDIT;
        if (clr_c) begin
            edit_nxt_c = '0;
        end else if (inc_c && !dec_c) begin
            edit_nxt_c = EDIT + 4'd1;
        end else if (dec_c && !inc_c) begin
            edit_nxt_c = EDIT - 4'd1;
        end
    end

    // Commit captures the post-update edit value of the same cycle
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            EDIT       <= '0;
            NUMBER     <= '0;
            NUMBER_VLD <= 1'b0;
        end else begin
            EDIT       <= edit_nxt_c;
            NUMBER_VLD <= commit_c;
            if (commit_c) begin
                NUMBER <= edit_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_hex_nibble_entry.sv
// Scoreboard bench for hex_nibble_entry: expected EDIT changes and NUMBER commits are queued
// by the stimulus thread and checked by a negedge monitor. Honours AUTOREPEAT_EN.
module tb_hex_nibble_entry;
    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic [3:0] KEY      = 4'hF;
    logic [3:0] EDIT;
    logic [3:0] NUMBER;
    logic       NUMBER_VLD;
    logic [3:0] KEY_STATE;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [3:0] edit_q[$];
    logic [3:0] num_q[$];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  prev_edit = 4'h0;
    logic [3:0]  exp_v;
    logic [31:0] act;
    chk_t        c;

    hex_nibble_entry #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .KEY       (KEY),
        .EDIT      (EDIT),
        .NUMBER    (NUMBER),
        .NUMBER_VLD(NUMBER_VLD),
        .KEY_STATE (KEY_STATE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Monitor: pops expected outputs on observed changes and services snapshot checks
    always @(negedge CLOCK_50) begin
        if (RESET) begin
            prev_edit = EDIT;
        end else begin
            if (EDIT !== prev_edit) begin
                n_cmp++;
                if (edit_q.size() == 0) begin
                    n_err++;
                    $display("FAIL edit_change: got %h, required no change", EDIT);
                end else begin
                    exp_v = edit_q.pop_front();
                    if (EDIT !== exp_v) begin
                        n_err++;
                        $display("FAIL edit_change: got %h, required %h", EDIT, exp_v);
                    end
                end
                prev_edit = EDIT;
            end
            if (NUMBER_VLD !== 1'b0) begin
                n_cmp++;
                if (num_q.size() == 0) begin
                    n_err++;
                    $display("FAIL number_commit: got vld=%b number=%h, required no pulse", NUMBER_VLD, NUMBER);
                end else begin
                    exp_v = num_q.pop_front();
                    if (NUMBER !== exp_v) begin
                        n_err++;
                        $display("FAIL number_commit: got %h, required %h", NUMBER, exp_v);
                    end
                end
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                0:       act = 32'(EDIT);
                1:       act = 32'(NUMBER);
                2:       act = 32'(KEY_STATE);
                3:       act = 32'(NUMBER_VLD);
                4:       act = 32'(edit_q.size());
                default: act = 32'(num_q.size());
            endcase
            n_cmp++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s: got %0h, required %0h", c.name, act, c.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic expect_now(input string name, input int kind, input logic [31:0] exp);
        chk_q.push_back('{name, kind, exp});
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        KEY = 4'hF & ~mask;
        tick(hold);
        KEY = 4'hF;
        tick(12);
    endtask

    initial begin
        // Reset state
        tick(3);
        expect_now("rst_edit", 0, 32'h0);
        expect_now("rst_number", 1, 32'h0);
        expect_now("rst_key_state", 2, 32'h0);
        expect_now("rst_vld", 3, 32'h0);
        tick(1);
        RESET = 1'b0;
        tick(20);
        expect_now("idle_edit", 0, 32'h0);
        expect_now("idle_number", 1, 32'h0);

        // Glitch shorter than the debounce window
        KEY = 4'hE;
        tick(3);
        KEY = 4'hF;
        tick(12);
        expect_now("glitch_key_state", 2, 32'h0);
        expect_now("glitch_edit", 0, 32'h0);

        // Exactly DEBOUNCE_CYCLES low is accepted
        edit_q.push_back(4'h1);
        press(4'h1, 4);
        expect_now("min_press_edit", 0, 32'h1);

        // Clear, three INC, commit
        edit_q.push_back(4'h0);
        press(4'h4, 10);
        for (int i = 1; i <= 2; i++) begin
            edit_q.push_back(4'(i));
            press(4'h1, 10);
        end
        edit_q.push_back(4'h3);
        KEY = 4'hE;
        tick(9);
        expect_now("held_key_state", 2, 32'h1);
        KEY = 4'hF;
        tick(12);
        num_q.push_back(4'h3);
        press(4'h8, 10);
        expect_now("commit_edit", 0, 32'h3);
        expect_now("commit_number", 1, 32'h3);

        // Wrap both ways
        edit_q.push_back(4'h0);
        press(4'h4, 10);
        edit_q.push_back(4'hF);
        press(4'h2, 10);
        expect_now("wrap_dec", 0, 32'hF);
        edit_q.push_back(4'h0);
        press(4'h1, 10);
        expect_now("wrap_inc", 0, 32'h0);

        // INC+DEC cancel, CLEAR beats INC
        for (int i = 1; i <= 7; i++) begin
            edit_q.push_back(4'(i));
            press(4'h1, 10);
        end
        press(4'h3, 10);
        expect_now("inc_dec_cancel", 0, 32'h7);
        edit_q.push_back(4'h0);
        press(4'h5, 10);
        expect_now("clear_priority", 0, 32'h0);
        expect_now("number_stable", 1, 32'h3);

        // INC with COMMIT commits post-increment value; repeat commit still pulses
        for (int i = 1; i <= 3; i++) begin
            edit_q.push_back(4'(i));
            press(4'h1, 10);
        end
        edit_q.push_back(4'h4);
        num_q.push_back(4'h4);
        press(4'h9, 10);
        num_q.push_back(4'h4);
        press(4'h8, 10);
        expect_now("inc_commit_number", 1, 32'h4);

        // Long hold of INC
`ifdef AUTOREPEAT_EN
        for (int i = 5; i <= 11; i++) begin
            edit_q.push_back(4'(i));
        end
        press(4'h1, 50);
        expect_now("hold_edit", 0, 32'hB);
        edit_q.push_back(4'hC);
`else
        edit_q.push_back(4'h5);
        press(4'h1, 50);
        expect_now("hold_edit", 0, 32'h5);
        edit_q.push_back(4'h6);
`endif

        // Reset in the middle of a hold
        KEY = 4'hE;
        tick(15);
        RESET = 1'b1;
        tick(1);
        expect_now("midrst_edit", 0, 32'h0);
        expect_now("midrst_number", 1, 32'h0);
        expect_now("midrst_vld", 3, 32'h0);
        expect_now("midrst_key_state", 2, 32'h0);
        KEY = 4'hF;
        tick(2);
        RESET = 1'b0;
        tick(12);
        expect_now("post_rst_edit", 0, 32'h0);
        expect_now("edit_q_drained", 4, 32'h0);
        expect_now("num_q_drained", 5, 32'h0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
